fit_display_sequencer: RTL and testbench

- Schedules the FitTracker metrics onto the shared 4-digit 7-segment display path.
- Rotates through four metrics: step count, distance, early-high-rate seconds and high-rate time.
- Each selected metric goes through one shared sequential binary-to-BCD converter.
- Presents four BCD digits plus a metric code and a one-cycle update strobe to the segment driver.

---
 rtl/fit_pkg.sv | 46 ++++
 rtl/fit_display_sequencer_if.sv | 10 +
 rtl/fit_bin2bcd_seq.sv | 62 ++++++
 rtl/fit_display_sequencer.sv | 139 +++++++++++++
 tb/tb_fit_display_sequencer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fit_pkg.sv
// Shared types and helpers for the FitTracker display sequencer.
// Leading-zero blanking is built only with FIT_DISP_BLANK_EN.
package fit_pkg;

   localparam logic [1:0] MET_STEPS   = 2'd0;
   localparam logic [1:0] MET_DIST    = 2'd1;
   localparam logic [1:0] MET_SEC     = 2'd2;
   localparam logic [1:0] MET_SECTIME = 2'd3;

   localparam logic [3:0] BCD_BLANK = 4'hF;
   localparam int         SAT_MAX   = 9999;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CONV,
      S_DONE,
      S_HOLD
   } state_t;

   function automatic logic [15:0] add3(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (r[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // ones digit always stays visible
   function automatic logic [15:0] blank_lz(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      if (b[15:12] == 4'd0) begin
         r[15:12] = BCD_BLANK;
         if (b[11:8] == 4'd0) begin
            r[11:8] = BCD_BLANK;
            if (b[7:4] == 4'd0)
               r[7:4] = BCD_BLANK;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fit_display_sequencer_if.sv
// Display bundle from the sequencer to the segment driver.
// One-cycle disp_valid qualifies bcd and metric.
interface fit_disp_if;
   logic [15:0] bcd;
   logic [1:0]  metric;
   logic        disp_valid;

   modport master (output bcd, output metric, output disp_valid);
   modport slave  (input bcd, input metric, input disp_valid);
endinterface

// File: rtl/fit_bin2bcd_seq.sv
// Iterative double-dabble binary to 4-digit BCD converter.
// The first iteration runs on the start edge; done pulses after the last.
module fit_bin2bcd_seq
   import fit_pkg::*;
#(
   parameter int CONV_BITS = 14
) (
   input  logic                 clk,
   input  logic                 RESET_N,
   input  logic                 start,
   input  logic [CONV_BITS-1:0] bin,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          bcd
);

   localparam int CW = $clog2(CONV_BITS + 1);

   logic [CONV_BITS-1:0] sr;
   logic [CW-1:0]        cnt;
   logic                 first;
   logic [15:0]          cur_bcd;
   logic [CONV_BITS-1:0] cur_sr;
   logic [15:0]          adj;
   logic [15+CONV_BITS:0] sh;
   logic [15:0]          nxt_bcd;
   logic [CONV_BITS-1:0] nxt_sr;

   assign first   = start & ~busy;
   assign cur_bcd = first ? 16'd0 : bcd;
   assign cur_sr  = first ? bin : sr;
   assign adj     = add3(cur_bcd);
   assign sh      = {adj, cur_sr} << 1;
   assign {nxt_bcd, nxt_sr} = sh;

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         bcd  <= '0;
         sr   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (first) begin
            bcd  <= nxt_bcd;
            sr   <= nxt_sr;
            cnt  <= CW'(CONV_BITS - 1);
            busy <= 1'b1;
         end else if (busy) begin
            bcd <= nxt_bcd;
            sr  <= nxt_sr;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fit_display_sequencer.sv
// Rotates FitTracker metrics through one BCD converter onto the display.
// Define FIT_DISP_BLANK_EN to blank leading zero digits.
module fit_display_sequencer
   import fit_pkg::*;
#(
   parameter int ROT_SEC   = 2,
   parameter int CONV_BITS = 14
) (
   input  logic           clk,
   input  logic           RESET_N,
   input  logic           tick_1hz,
   input  logic           next_btn,
   input  logic [13:0]    stepcnt,
   input  logic [8:0]     distance,
   input  logic [3:0]     sec,
   input  logic [8:0]     sectime,
   input  logic           SI,
   fit_disp_if.master     disp,
   output logic           si_led
);

   localparam int TW = $clog2(ROT_SEC + 1);

   state_t               state, state_n;
   logic [1:0]           sel, sel_n;
   logic [TW-1:0]        tcnt, tcnt_n, tcnt_inc;
   logic                 pend_tick, pend_next;
   logic                 ev_tick, ev_next;
   logic [CONV_BITS-1:0] raw, load_val;
   logic                 conv_start, conv_busy, conv_done;
   logic [15:0]          conv_bcd, shown;
   logic [15:0]          bcd_q;
   logic [1:0]           metric_q;
   logic                 disp_valid;

   always_comb begin
      raw = '0;
      unique case (sel)
         MET_STEPS:   raw = CONV_BITS'(stepcnt);
         MET_DIST:    raw = CONV_BITS'(distance);
         MET_SEC:     raw = CONV_BITS'(sec);
         MET_SECTIME: raw = CONV_BITS'(sectime);
         default:     raw = '0;
      endcase
   end

   assign load_val = (raw > CONV_BITS'(SAT_MAX)) ? CONV_BITS'(SAT_MAX) : raw;

   fit_bin2bcd_seq #(.CONV_BITS(CONV_BITS)) u_conv (
      .clk     (clk),
      .RESET_N (RESET_N),
      .start   (conv_start),
      .bin     (load_val),
      .busy    (conv_busy),
      .done    (conv_done),
      .bcd     (conv_bcd)
   );

`ifdef FIT_DISP_BLANK_EN
   assign shown = blank_lz(conv_bcd);
`else
   assign shown = conv_bcd;
`endif

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) state <= S_IDLE;
      else          state <= state_n;
   end

   assign ev_next  = next_btn | pend_next;
   assign ev_tick  = tick_1hz | pend_tick;
   assign tcnt_inc = tcnt + 1'b1;

   always_comb begin
      state_n = state;
      sel_n   = sel;
      tcnt_n  = tcnt;
      unique case (state)
         S_IDLE: state_n = S_LOAD;
         S_LOAD: state_n = S_CONV;
         S_CONV: if (conv_done) state_n = S_DONE;
         S_DONE: state_n = S_HOLD;
         S_HOLD: begin
            if (ev_next) begin
               sel_n   = sel + 2'd1;
               tcnt_n  = '0;
               state_n = S_LOAD;
            end else if (ev_tick) begin
               if (tcnt_inc == TW'(ROT_SEC)) begin
                  sel_n  = sel + 2'd1;
                  tcnt_n = '0;
               end else begin
                  tcnt_n = tcnt_inc;
               end
               state_n = S_LOAD;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      conv_start = (state == S_LOAD) && !conv_busy;
      disp_valid = (state == S_DONE);
   end

   // events arriving outside HOLD wait here for the next HOLD cycle
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         sel       <= '0;
         tcnt      <= '0;
         pend_tick <= 1'b0;
         pend_next <= 1'b0;
         bcd_q     <= '0;
         metric_q  <= '0;
         si_led    <= 1'b0;
      end else begin
         si_led <= SI;
         sel    <= sel_n;
         tcnt   <= tcnt_n;
         if (state == S_HOLD) begin
            pend_tick <= 1'b0;
            pend_next <= 1'b0;
         end else begin
            pend_tick <= pend_tick | tick_1hz;
            pend_next <= pend_next | next_btn;
         end
         if (state == S_CONV && conv_done) begin
            bcd_q    <= shown;
            metric_q <= sel;
         end
      end
   end

   assign disp.bcd        = bcd_q;
   assign disp.metric     = metric_q;
   assign disp.disp_valid = disp_valid;

endmodule

// File: tb/tb_fit_display_sequencer.sv
// Scoreboard bench for fit_display_sequencer.
// Expected displays are queued at stimulus time and popped by a monitor.
module tb_fit_display_sequencer;

   typedef struct packed {
      logic [1:0]  m;
      logic [15:0] b;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic        nxt = 1'b0;
   logic [13:0] stepcnt = '0;
   logic [8:0]  distance = '0;
   logic [3:0]  sec = '0;
   logic [8:0]  sectime = '0;
   logic        si = 1'b0;
   logic        si_led;

   fit_disp_if dif();

   fit_display_sequencer #(.ROT_SEC(2), .CONV_BITS(14)) dut (
      .clk      (clk),
      .RESET_N  (rst_n),
      .tick_1hz (tick),
      .next_btn (nxt),
      .stepcnt  (stepcnt),
      .distance (distance),
      .sec      (sec),
      .sectime  (sectime),
      .SI       (si),
      .disp     (dif.master),
      .si_led   (si_led)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   disp_cnt = 0;
   int   last_cyc = 0;
   int   rel_cyc = 0;
   logic [1:0] last_metric = '0;
   exp_t q[$];
   int   m_sel = 0;
   int   m_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] fmt(input int v);
      int x;
      int d3, d2, d1, d0;
      logic [15:0] r;
      x  = (v > 9999) ? 9999 : v;
      d3 = x / 1000;
      d2 = (x / 100) % 10;
      d1 = (x / 10) % 10;
      d0 = x % 10;
      r  = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
`ifdef FIT_DISP_BLANK_EN
      if (d3 == 0) begin
         r[15:12] = 4'hF;
         if (d2 == 0) begin
            r[11:8] = 4'hF;
            if (d1 == 0) r[7:4] = 4'hF;
         end
      end
`endif
      return r;
   endfunction

   function automatic int metval(input int m);
      case (m)
         0: return int'(stepcnt);
         1: return int'(distance);
         2: return int'(sec);
         default: return int'(sectime);
      endcase
   endfunction

   task automatic push(input int m);
      exp_t e;
      e.m = 2'(m);
      e.b = fmt(metval(m));
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && dif.disp_valid) begin
         disp_cnt++;
         last_cyc    = cyc;
         last_metric = dif.metric;
         if (q.size() == 0) begin
            chk("unexpected_disp", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("disp_metric", int'(dif.metric), int'(e.m));
            chk("disp_bcd", int'(dif.bcd), int'(e.b));
         end
      end
   end

   task automatic wait_disp(input int n);
      int k;
      k = 0;
      while (disp_cnt < n && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("disp_arrived", int'(disp_cnt >= n), 1);
   endtask

   task automatic trig(input bit t, input bit n);
      @(posedge clk);
      #1;
      tick = t;
      nxt  = n;
      if (n) begin
         m_sel = (m_sel + 1) % 4;
         m_cnt = 0;
      end else if (t) begin
         m_cnt++;
         if (m_cnt == 2) begin
            m_sel = (m_sel + 1) % 4;
            m_cnt = 0;
         end
      end
      push(m_sel);
      @(posedge clk);
      #1;
      tick = 1'b0;
      nxt  = 1'b0;
   endtask

   task automatic do_reset();
      int base;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      q.delete();
      m_sel = 0;
      m_cnt = 0;
      chk("rst_bcd", int'(dif.bcd), 0);
      chk("rst_metric", int'(dif.metric), 0);
      chk("rst_valid", int'(dif.disp_valid), 0);
      chk("rst_si_led", int'(si_led), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      rel_cyc = cyc;
      base    = disp_cnt;
      push(0);
      wait_disp(base + 1);
      chk("startup_latency", last_cyc - rel_cyc, 16);
   endtask

   task automatic tick_and_wait();
      int base;
      base = disp_cnt;
      trig(1'b1, 1'b0);
      wait_disp(base + 1);
      repeat (20) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seq [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
      int base;
      int d1;

      si = 1'b1;
      do_reset();
      chk("si_led_follow", int'(si_led), 1);
      si = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("si_led_clear", int'(si_led), 0);

      stepcnt  = 14'd1234;
      distance = 9'd321;
      sec      = 4'd7;
      sectime  = 9'd456;
      repeat (5) @(posedge clk);
      tick_and_wait();
      chk("tick1_metric", int'(last_metric), 0);
      repeat (80) @(posedge clk);
      tick_and_wait();
      chk("tick2_metric", int'(last_metric), 1);

      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick_and_wait();
         chk("rot_seq", int'(last_metric), seq[i]);
      end

      stepcnt = 14'h3FFF;
      tick_and_wait();
      chk("sat_metric", int'(last_metric), 0);

      base = disp_cnt;
      trig(1'b1, 1'b1);
      wait_disp(base + 1);
      chk("both_metric", int'(last_metric), 1);
      repeat (20) @(posedge clk);
      tick_and_wait();
      chk("cnt_cleared", int'(last_metric), 1);
      tick_and_wait();
      chk("after_two", int'(last_metric), 2);

      base = disp_cnt;
      trig(1'b1, 1'b0);
      repeat (4) @(posedge clk);
      sec     = 4'd9;
      sectime = 9'd300;
      trig(1'b1, 1'b0);
      wait_disp(base + 1);
      d1 = last_cyc;
      wait_disp(base + 2);
      chk("pending_gap", last_cyc - d1, 17);
      repeat (20) @(posedge clk);

      trig(1'b1, 1'b0);
      repeat (5) @(posedge clk);
      do_reset();

      repeat (40) @(posedge clk);
      chk("queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
